// File: rtl/tri_bus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tri_bus_pkg : shared types and width helpers for tri_bus_arbiter. Rev 1.0
// ---------------------------------------------------------------------------
package tri_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam int c_def_num_masters = 4;
    localparam int c_def_turnaround  = 1;
    localparam int c_def_max_hold    = 8;

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Width of an index into n items (never below one bit).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int c_def_hold_w = cnt_w(c_def_max_hold);
    localparam int c_def_turn_w = cnt_w(c_def_turnaround);

endpackage
`default_nettype wire

// File: rtl/tri_bus_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tri_bus_arbiter_if : request/grant/enable bundle of the tri-state bus. Rev 1.0
// ---------------------------------------------------------------------------
interface tri_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int c_ow = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] gnt;
    logic [NUM_MASTERS-1:0] oe_;
    logic [c_ow-1:0]        owner;
    logic                   owner_valid;
    logic                   bus_busy;

    modport master (
        output req,
        input  gnt,
        input  oe_,
        input  owner,
        input  owner_valid,
        input  bus_busy
    );

    modport slave (
        input  req,
        output gnt,
        output oe_,
        output owner,
        output owner_valid,
        output bus_busy
    );
endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, index i_ptr has top priority. Rev 1.0
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int OW          = 2
) (
    input  wire logic [NUM_MASTERS-1:0] i_req,
    input  wire logic [OW-1:0]          i_ptr,
    output logic      [OW-1:0]          o_winner,
    output logic                        o_any
);
    logic [OW:0]   w_sum;
    logic [OW-1:0] w_idx;

    // Scan from the far end back toward i_ptr so the closest requester wins last.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            w_sum = {1'b0, i_ptr} + (OW + 1)'(i);
            if (w_sum >= (OW + 1)'(NUM_MASTERS)) begin
                w_idx = OW'(w_sum - (OW + 1)'(NUM_MASTERS));
            end else begin
                w_idx = OW'(w_sum);
            end
            if (i_req[w_idx]) begin
                o_winner = w_idx;
                o_any    = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/tri_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tri_bus_arbiter : round-robin owner of a tri-state bus with dead cycles. Rev 1.0
// ---------------------------------------------------------------------------
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int TURNAROUND  = 1,
    parameter int MAX_HOLD    = 8
) (
    input  wire logic          clk,
    input  wire logic          reset_,
    tri_bus_arbiter_if.slave   bus
);
    localparam int c_ow     = idx_w(NUM_MASTERS);
    localparam int c_hold_w = cnt_w(MAX_HOLD);
    localparam int c_turn_w = cnt_w(TURNAROUND);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_chk_num_masters
        $error("tri_bus_arbiter: NUM_MASTERS must be 2..16");
    end
    if (TURNAROUND < 1 || TURNAROUND > 7) begin : g_chk_turnaround
        $error("tri_bus_arbiter: TURNAROUND must be 1..7");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_chk_max_hold
        $error("tri_bus_arbiter: MAX_HOLD must be 2..255");
    end

    state_t                 r_state,  w_state;
    logic [NUM_MASTERS-1:0] r_gnt,    w_gnt;
    logic [NUM_MASTERS-1:0] r_oe_n;
    logic [c_ow-1:0]        r_owner,  w_owner;
    logic                   r_valid,  w_valid;
    logic                   r_busy,   w_busy;
    logic [c_ow-1:0]        r_ptr,    w_ptr;
    logic [c_hold_w-1:0]    r_hold,   w_hold;
    logic [c_turn_w-1:0]    r_turn,   w_turn;

    logic [c_ow-1:0]        w_winner;
    logic                   w_any;
    logic                   w_others;
    logic                   w_hold_max;
    logic                   w_keep;

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .OW          (c_ow)
    ) u_rr_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // r_gnt is one-hot on the owner in GRANT, so this masks out only the owner.
    assign w_others   = |(bus.req & ~r_gnt);
    assign w_hold_max = (r_hold == c_hold_w'(MAX_HOLD));
    assign w_keep     = bus.req[r_owner] && !(w_hold_max && w_others);

    always_comb begin
        w_state = r_state;
        w_gnt   = r_gnt;
        w_owner = r_owner;
        w_valid = r_valid;
        w_busy  = r_busy;
        w_ptr   = r_ptr;
        w_hold  = r_hold;
        w_turn  = r_turn;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state           = ST_GRANT;
                    w_gnt             = '0;
                    w_gnt[w_winner]   = 1'b1;
                    w_owner           = w_winner;
                    w_valid           = 1'b1;
                    w_busy            = 1'b1;
                    w_hold            = c_hold_w'(1);
                end
            end
            ST_GRANT: begin
                if (w_keep) begin
                    if (!w_hold_max) begin
                        w_hold = r_hold + c_hold_w'(1);
                    end
                end else begin
                    w_state = ST_TURN;
                    w_gnt   = '0;
                    w_owner = '0;
                    w_valid = 1'b0;
                    w_hold  = '0;
                    w_turn  = c_turn_w'(TURNAROUND);
                    w_ptr   = (r_owner == c_ow'(NUM_MASTERS - 1)) ? '0 : r_owner + c_ow'(1);
                end
            end
            ST_TURN: begin
                if (r_turn == c_turn_w'(1)) begin
                    w_state = ST_IDLE;
                    w_busy  = 1'b0;
                    w_turn  = '0;
                end else begin
                    w_turn = r_turn - c_turn_w'(1);
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_gnt   = '0;
                w_owner = '0;
                w_valid = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_oe_n  <= '1;
            r_owner <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_turn  <= '0;
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_oe_n  <= ~w_gnt;
            r_owner <= w_owner;
            r_valid <= w_valid;
            r_busy  <= w_busy;
            r_ptr   <= w_ptr;
            r_hold  <= w_hold;
            r_turn  <= w_turn;
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.oe_         = r_oe_n;
    assign bus.owner       = r_owner;
    assign bus.owner_valid = r_valid;
    assign bus.bus_busy    = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_tri_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tri_bus_arbiter : scoreboard bench for tri_bus_arbiter (4 masters). Rev 1.0
// ---------------------------------------------------------------------------
module tb_tri_bus_arbiter;
    localparam int N  = 4;
    localparam int TA = 1;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic reset_;
    always #5 clk = ~clk;

    tri_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

    tri_bus_arbiter #(
        .NUM_MASTERS (N),
        .TURNAROUND  (TA),
        .MAX_HOLD    (MH)
    ) u_dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] oe;
        logic [1:0] owner;
        logic       valid;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    int m_state, m_owner, m_ptr, m_hold, m_turn;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_turn = 0;
    endtask

    // Reference behaviour: 0=IDLE 1=GRANT 2=TURN, advanced once per rising edge.
    task automatic model_step(input logic [3:0] r);
        int  w;
        bit  others;
        case (m_state)
            0: begin
                if (r != 4'b0) begin
                    w = -1;
                    for (int i = 0; i < N; i++) begin
                        if (w < 0 && r[(m_ptr + i) % N]) w = (m_ptr + i) % N;
                    end
                    m_owner = w;
                    m_hold  = 1;
                    m_state = 1;
                end
            end
            1: begin
                others = (r & ~(4'b0001 << m_owner)) != 4'b0;
                if (r[m_owner] && !(m_hold == MH && others)) begin
                    if (m_hold < MH) m_hold++;
                end else begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = 0;
                    m_turn  = TA;
                    m_state = 2;
                end
            end
            default: begin
                if (m_turn == 1) m_state = 0;
                else m_turn--;
            end
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.gnt   = (m_state == 1) ? (4'b0001 << m_owner) : 4'b0000;
        e.oe    = ~e.gnt;
        e.owner = (m_state == 1) ? 2'(m_owner) : 2'b00;
        e.valid = (m_state == 1);
        e.busy  = (m_state != 0);
        return e;
    endfunction

    // One clock: compare the outputs of the last edge, then drive the next request.
    task automatic cycle(input logic [3:0] r, output logic [3:0] g_seen);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("gnt",         32'(bus.gnt),         32'(e.gnt));
            check_eq("oe_",         32'(bus.oe_),         32'(e.oe));
            check_eq("owner",       32'(bus.owner),       32'(e.owner));
            check_eq("owner_valid", 32'(bus.owner_valid), 32'(e.valid));
            check_eq("bus_busy",    32'(bus.bus_busy),    32'(e.busy));
        end
        g_seen  = bus.gnt;
        bus.req = r;
        model_step(r);
        exp_q.push_back(model_out());
    endtask

    task automatic idle_cycles(input int n);
        logic [3:0] g;
        for (int i = 0; i < n; i++) cycle(4'b0000, g);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] g;
        logic [3:0] expg;
        bit         seen_gap;
        bit         wrap_done;

        reset_  = 1'b0;
        bus.req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            check_eq("reset_oe_",      32'(bus.oe_),      32'hF);
            check_eq("reset_gnt",      32'(bus.gnt),      32'h0);
            check_eq("reset_bus_busy", 32'(bus.bus_busy), 32'h0);
        end
        @(negedge clk);
        bus.req = 4'b0000;
        reset_  = 1'b1;
        model_reset();
        exp_q.push_back(model_out());

        // All masters requesting: fixed 8-cycle grants separated by 2 dead cycles.
        for (int j = 0; j <= 50; j++) begin
            cycle(4'b1111, g);
            if (j >= 1) begin
                expg = (((j - 1) % 10) < MH) ? (4'b0001 << (((j - 1) / 10) % N)) : 4'b0000;
                check_eq("rr_schedule", 32'(g), 32'(expg));
            end
        end
        idle_cycles(4);

        cycle(4'b0100, g);
        cycle(4'b0100, g);
        check_eq("single_gnt", 32'(g), 32'b0100);
        cycle(4'b0100, g);
        cycle(4'b0000, g);
        check_eq("single_held", 32'(g), 32'b0100);
        cycle(4'b0000, g);
        check_eq("single_release", 32'(g), 32'b0000);
        idle_cycles(3);

        for (int i = 0; i < 3; i++) cycle(4'b1000, g);
        check_eq("wrap_owner3", 32'(g), 32'b1000);
        seen_gap  = 1'b0;
        wrap_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            cycle(4'b1001, g);
            if (g == 4'b0000) seen_gap = 1'b1;
            else if (seen_gap && !wrap_done) begin
                check_eq("wrap_next_owner", 32'(g), 32'b0001);
                wrap_done = 1'b1;
            end
        end
        check_eq("wrap_seen", 32'(wrap_done), 32'd1);
        idle_cycles(4);

        for (int i = 0; i < 20; i++) begin
            cycle(4'b0010, g);
            if (i >= 2) check_eq("sole_hold", 32'(g), 32'b0010);
        end
        cycle(4'b0011, g);
        check_eq("sole_still_owner", 32'(g), 32'b0010);
        cycle(4'b0011, g);
        check_eq("sole_release", 32'(g), 32'b0000);
        cycle(4'b0011, g);
        check_eq("sole_idle_gap", 32'(g), 32'b0000);
        cycle(4'b0011, g);
        check_eq("sole_next", 32'(g), 32'b0001);
        idle_cycles(4);

        cycle(4'b0001, g);
        cycle(4'b0001, g);
        cycle(4'b0001, g);
        check_eq("pre_reset_gnt", 32'(g), 32'b0001);
        @(posedge clk);
        #2;
        reset_ = 1'b0;
        #1;
        check_eq("async_oe_",         32'(bus.oe_),         32'hF);
        check_eq("async_gnt",         32'(bus.gnt),         32'h0);
        check_eq("async_owner_valid", 32'(bus.owner_valid), 32'h0);
        check_eq("async_bus_busy",    32'(bus.bus_busy),    32'h0);
        exp_q.delete();
        @(negedge clk);
        reset_ = 1'b1;
        model_reset();
        model_step(bus.req);
        exp_q.push_back(model_out());
        cycle(4'b0001, g);
        check_eq("reset_regrant", 32'(g), 32'b0001);
        cycle(4'b0001, g);
        idle_cycles(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tri_bus_arbiter.md
# tri_bus_arbiter

Sequential arbiter that owns a shared tri-state bus and generates the active-low output enables (`oe_`) that drive the bus's tri-state drivers. It sits directly upstream of the tri-state mux/driver stage: masters raise requests, the arbiter grants one at a time round-robin, and it inserts dead cycles between owners so two drivers never overlap on the bus. All outputs are registered, so enables are glitch-free and never momentarily overlap.

## Interface
- `NUM_MASTERS`, 4: number of requesting masters / tri-state drivers on the bus (2..16).
- `TURNAROUND`, 1: dead cycles with all enables high between successive owners (1..7; 0 illegal).
- `MAX_HOLD`, 8: maximum consecutive grant cycles while another master is requesting (2..255).
- `clk` input 1: single clock; all state on rising edge.
- `reset_` input 1: asynchronous, active-low reset.
- `req` input NUM_MASTERS: per-master bus request, level-sensitive.
- `gnt` output NUM_MASTERS: one-hot grant, all-zero when no owner.
- `oe_` output NUM_MASTERS: active-low tri-state enables, bitwise `~gnt`, registered.
- `owner` output $clog2(NUM_MASTERS): index of current owner; 0 when none.
- `owner_valid` output 1: high while a grant is active.
- `bus_busy` output 1: high in GRANT and TURN states.

## Operation
- States: IDLE, GRANT, TURN.
- Reset (async, immediate): state IDLE, `gnt`=0, `oe_`=all 1 (all drivers high-Z), `owner`=0, `owner_valid`=0, `bus_busy`=0, round-robin pointer `ptr`=0, hold counter 0, turn counter 0.
- IDLE: if any `req` bit set, pick first set bit scanning upward from `ptr` with wrap (index `ptr` has highest priority). Next edge: `gnt`/`oe_` for winner, `owner`=winner, hold counter=1, state GRANT. No request: stay IDLE.
- GRANT: owner retains bus while `req[owner]`=1 and NOT (hold counter = MAX_HOLD and any other `req` bit set). Hold counter increments per GRANT cycle, saturates at MAX_HOLD.
- Release (owner drops `req`, or hold expiry with another requester): next edge `gnt`=0, `oe_`=all 1, `owner_valid`=0, `ptr`=(owner+1) mod NUM_MASTERS, turn counter=TURNAROUND, state TURN.
- Sole requester at hold expiry keeps bus; counter stays saturated; released on first cycle another request appears.
- TURN: enables all high; turn counter decrements per cycle; at 1 go to IDLE. Requests ignored in TURN.
- Invariant: at most one `oe_` bit low in any cycle; no owner change without ≥TURNAROUND all-high cycles.
- `req` changes in GRANT from non-owners only affect expiry decision; they never preempt before MAX_HOLD.
- `ptr` wraps from NUM_MASTERS-1 to 0.

## Timing
- IDLE request at edge N sampled → `gnt` high after edge N+1 (1-cycle latency).
- Owner release sampled at edge N → `gnt`=0 after N+1; next grant after edge N+1+TURNAROUND+1; bus undriven for TURNAROUND+1 cycles.
- Owner with competitors keeps bus exactly MAX_HOLD cycles.
- `reset_` low mid-grant: `oe_` all high asynchronously, no wait for clock; first grant possible one edge after IDLE re-entry with `reset_` high.
- Outputs depend only on flops; no combinational path from `req` to `gnt`/`oe_`.

## Structure
- Package `tri_bus_pkg`: state enum (IDLE, GRANT, TURN), counter-width localparams derived from MAX_HOLD/TURNAROUND.
- Sub-module `rr_pick`: combinational round-robin picker (`req`, `ptr` → `winner`, `any`); arbiter instantiates it once.
- Parameter range checks in elaboration-time assertions.

## Test plan
- Reset: hold `reset_` low, toggle `req`=4'b1111 → `oe_`=4'b1111, `gnt`=0, `bus_busy`=0 throughout.
- Single request: `req`=4'b0100 from IDLE → `gnt`=4'b0100, `oe_`=4'b1011, `owner`=2 one cycle later; drop `req` → `oe_`=4'b1111 next cycle, TURN 1 cycle, IDLE.
- Round-robin: `req`=4'b1111 held, MAX_HOLD=8 → owners 0,1,2,3,0 each 8 cycles, 2 all-high cycles between grants.
- Wrap/pointer: owner 3 releases, `req`=4'b1001 → next owner 0.
- Sole requester: `req`=4'b0010 for 20 cycles → continuous grant; raise `req[0]` at cycle 20 → master 1 released next edge, master 0 granted after TURN+IDLE.
- Async reset mid-grant: assert `reset_` low between edges while `gnt`=4'b0001 → `oe_`=4'b1111 before next edge; after release, `req`=4'b0001 → regrant in 1 cycle with `ptr`=0.
